harvard_mem_responder: RTL and testbench

- Memory-side responder for the CPU's Harvard bus. It serves the combinational instruction read port, and the data port with combinational read and single-cycle write.
- Contains an instruction ROM region and a data RAM region.
- A boot-load FSM streams a program image into both regions while it holds the CPU in reset. It then releases the CPU, counts run cycles, and flags completion when the CPU drops active.
- Sits between the bench/top level and the CPU core.

---
 rtl/harvard_mem_responder_pkg.sv | 19 +
 rtl/harvard_mem_responder_mem_region.sv | 39 +++
 rtl/harvard_mem_responder.sv | 138 +++++++++++++
 tb/tb_harvard_mem_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/harvard_mem_responder_pkg.sv
// Shared types and constants for the Harvard-bus memory responder.
package harvard_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_HOLD,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [31:0] INSTR_RESET_VECTOR = 32'hBFC00000;
    localparam logic [31:0] HALT_ADDR          = 32'h0;

    // One past the last byte of a region; 33 bits so base + size cannot wrap.
    function automatic logic [32:0] region_limit(input logic [31:0] base, input int aw);
        return {1'b0, base} + (33'd1 << (aw + 2));
    endfunction

endpackage

// File: rtl/harvard_mem_responder_mem_region.sv
// Word-addressed memory region: one write port, combinational byte-addressed read
// with range check against its base/depth.
module harvard_mem_responder_mem_region
    import harvard_mem_responder_pkg::*;
#(
    parameter logic [31:0] BASE = 32'h0,
    parameter int          AW   = 10
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_index,
    input  logic [31:0]   wr_data,
    input  logic [31:0]   addr,
    output logic          in_range,
    output logic [AW-1:0] index,
    output logic [31:0]   rd_data
);

    localparam int          DEPTH = 1 << AW;
    localparam logic [32:0] LIMIT = region_limit(BASE, AW);

    logic [31:0] mem [DEPTH];
    logic [31:0] offset;
    logic        unused_offset_bits;

    assign offset   = addr - BASE;
    assign index    = offset[AW+1:2];
    assign in_range = (addr >= BASE) && ({1'b0, addr} < LIMIT);
    // Out-of-range reads return 0 so a stray fetch decodes as a nop.
    assign rd_data  = in_range ? mem[index] : 32'h0;

    assign unused_offset_bits = ^{offset[31:AW+2], offset[1:0]};

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_index] <= wr_data;
    end

endmodule

// File: rtl/harvard_mem_responder.sv
// Harvard-bus memory responder: boot-loads instruction/data regions, holds the CPU
// in reset, then serves the CPU and counts run cycles until it halts.
module harvard_mem_responder
    import harvard_mem_responder_pkg::*;
#(
    parameter int          INSTR_AW   = 10,
    parameter int          DATA_AW    = 10,
    parameter logic [31:0] INSTR_BASE = INSTR_RESET_VECTOR,
    parameter logic [31:0] DATA_BASE  = 32'h00000000,
    parameter int          RST_HOLD   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_data,
    input  logic        load_sel,
    input  logic        load_last,
    output logic        cpu_reset,
    input  logic        cpu_active,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_write,
    input  logic        data_read,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        done,
    output logic        load_overflow,
    output logic        bus_error,
    output logic [31:0] run_cycles
);

    localparam logic [INSTR_AW:0] INSTR_DEPTH = {1'b1, {INSTR_AW{1'b0}}};
    localparam logic [DATA_AW:0]  DATA_DEPTH  = {1'b1, {DATA_AW{1'b0}}};

    state_t              state, state_nxt;
    logic [INSTR_AW:0]   instr_cnt;
    logic [DATA_AW:0]    data_cnt;
    logic [31:0]         hold_cnt;

    logic                beat, instr_full, data_full;
    logic                instr_we, data_load_we, cpu_wr, data_we;
    logic                data_hit, instr_hit;
    logic [DATA_AW-1:0]  data_index, data_wr_index;
    logic [INSTR_AW-1:0] instr_index;
    logic [31:0]         data_wr_data;
    logic                unused_inputs;

    assign beat         = load_valid && load_ready;
    assign instr_full   = (instr_cnt == INSTR_DEPTH);
    assign data_full    = (data_cnt == DATA_DEPTH);
    assign instr_we     = beat && !load_sel && !instr_full;
    assign data_load_we = beat && load_sel && !data_full;
    assign cpu_wr       = (state == ST_RUN) && data_write;
    assign data_we      = data_load_we || (cpu_wr && data_hit);
    // The data array's single write port is owned by the loader in LOAD, by the CPU otherwise.
    assign data_wr_index = (state == ST_LOAD) ? data_cnt[DATA_AW-1:0] : data_index;
    assign data_wr_data  = (state == ST_LOAD) ? load_data : data_writedata;

    assign unused_inputs = ^{data_read, instr_hit, instr_index};

    harvard_mem_responder_mem_region #(.BASE(INSTR_BASE), .AW(INSTR_AW)) u_instr_region (
        .clk      (clk),
        .wr_en    (instr_we),
        .wr_index (instr_cnt[INSTR_AW-1:0]),
        .wr_data  (load_data),
        .addr     (instr_address),
        .in_range (instr_hit),
        .index    (instr_index),
        .rd_data  (instr_readdata)
    );

    harvard_mem_responder_mem_region #(.BASE(DATA_BASE), .AW(DATA_AW)) u_data_region (
        .clk      (clk),
        .wr_en    (data_we),
        .wr_index (data_wr_index),
        .wr_data  (data_wr_data),
        .addr     (data_address),
        .in_range (data_hit),
        .index    (data_index),
        .rd_data  (data_readdata)
    );

    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        cpu_reset  = 1'b0;
        done       = 1'b0;
        case (state)
            ST_LOAD: begin
                load_ready = 1'b1;
                cpu_reset  = 1'b1;
                if (load_valid && load_last)
                    state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                cpu_reset = 1'b1;
                if (hold_cnt == 32'(RST_HOLD - 1))
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // The CPU may still be coming out of reset on the first RUN cycle.
                if (!cpu_active && run_cycles != 32'd0)
                    state_nxt = ST_DONE;
            end
            ST_DONE: done = 1'b1;
            default: state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_LOAD;
            instr_cnt     <= '0;
            data_cnt      <= '0;
            hold_cnt      <= '0;
            run_cycles    <= '0;
            load_overflow <= 1'b0;
            bus_error     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (instr_we)
                instr_cnt <= instr_cnt + 1'b1;
            if (data_load_we)
                data_cnt <= data_cnt + 1'b1;
            if (beat && (load_sel ? data_full : instr_full))
                load_overflow <= 1'b1;
            if (state == ST_HOLD)
                hold_cnt <= hold_cnt + 32'd1;
            if (state == ST_RUN)
                run_cycles <= run_cycles + 32'd1;
            if (cpu_wr && !data_hit)
                bus_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_harvard_mem_responder.sv
// Scoreboard bench for harvard_mem_responder: expected read words are queued when the
// address is driven and popped when the combinational read is sampled.
module tb_harvard_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [31:0] load_data = '0;
    logic        load_sel = 1'b0;
    logic        load_last = 1'b0;
    logic        cpu_reset;
    logic        cpu_active = 1'b1;
    logic [31:0] instr_address = '0;
    logic [31:0] instr_readdata;
    logic [31:0] data_address = '0;
    logic        data_write = 1'b0;
    logic        data_read = 1'b0;
    logic [31:0] data_writedata = '0;
    logic [31:0] data_readdata;
    logic        done;
    logic        load_overflow;
    logic        bus_error;
    logic [31:0] run_cycles;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp;

    harvard_mem_responder dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .load_sel(load_sel), .load_last(load_last),
        .cpu_reset(cpu_reset), .cpu_active(cpu_active),
        .instr_address(instr_address), .instr_readdata(instr_readdata),
        .data_address(data_address), .data_write(data_write), .data_read(data_read),
        .data_writedata(data_writedata), .data_readdata(data_readdata),
        .done(done), .load_overflow(load_overflow), .bus_error(bus_error),
        .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    task automatic sb_push(input logic [31:0] w);
        exp_q.push_back(w);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic load_beat(input logic sel, input logic [31:0] w, input logic last);
        load_valid = 1'b1; load_sel = sel; load_data = w; load_last = last;
        @(posedge clk); #1;
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (cpu_reset !== 1'b1) begin n_err++; $display("FAIL reset_cpu_reset: got %b need 1", cpu_reset); end
        n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL reset_load_ready: got %b need 1", load_ready); end
        n_cmp++; if ({done, load_overflow, bus_error} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b need 000", {done, load_overflow, bus_error}); end
        n_cmp++; if (run_cycles !== 32'd0) begin n_err++; $display("FAIL reset_run_cycles: got %0d need 0", run_cycles); end
    endtask

    task automatic test_load_boot();
        cpu_active = 1'b1;
        load_beat(1'b0, 32'h24020005, 1'b0);
        load_beat(1'b0, 32'h00000008, 1'b0);
        load_beat(1'b0, 32'h00000000, 1'b0);
        load_beat(1'b1, 32'hDEADBEEF, 1'b1);
        n_cmp++; if ({cpu_reset, load_ready} !== 2'b10) begin n_err++; $display("FAIL hold0: got rst/rdy %b need 10", {cpu_reset, load_ready}); end
        @(posedge clk); #1;
        n_cmp++; if (cpu_reset !== 1'b1) begin n_err++; $display("FAIL hold1_cpu_reset: got %b need 1", cpu_reset); end
        @(posedge clk); #1;
        n_cmp++; if (cpu_reset !== 1'b0) begin n_err++; $display("FAIL run_entry_cpu_reset: got %b need 0", cpu_reset); end
        instr_address = 32'hBFC00004; sb_push(32'h00000008); #1;
        n_cmp++; exp = exp_q.pop_front();
        if (instr_readdata !== exp) begin n_err++; $display("FAIL ifetch_4: got %h need %h", instr_readdata, exp); end
        instr_address = 32'hBFC00000; sb_push(32'h24020005); #1;
        n_cmp++; exp = exp_q.pop_front();
        if (instr_readdata !== exp) begin n_err++; $display("FAIL ifetch_0: got %h need %h", instr_readdata, exp); end
        data_address = 32'h0; sb_push(32'hDEADBEEF); #1;
        n_cmp++; exp = exp_q.pop_front();
        if (data_readdata !== exp) begin n_err++; $display("FAIL dread_0: got %h need %h", data_readdata, exp); end
    endtask

    task automatic test_run_write();
        data_address = 32'h10; data_writedata = 32'h11111111; data_write = 1'b1;
        @(posedge clk); #1;
        data_writedata = 32'hCAFEF00D; sb_push(32'h11111111); #1;
        n_cmp++; exp = exp_q.pop_front();
        if (data_readdata !== exp) begin n_err++; $display("FAIL rw_same_cycle_old: got %h need %h", data_readdata, exp); end
        @(posedge clk); #1;
        data_write = 1'b0; sb_push(32'hCAFEF00D); #1;
        n_cmp++; exp = exp_q.pop_front();
        if (data_readdata !== exp) begin n_err++; $display("FAIL rw_new_value: got %h need %h", data_readdata, exp); end
        n_cmp++; if (bus_error !== 1'b0) begin n_err++; $display("FAIL rw_bus_error: got %b need 0", bus_error); end
    endtask

    task automatic test_bus_error();
        data_address = 32'h80000000; data_writedata = 32'h55555555; data_write = 1'b1;
        sb_push(32'h0); #1;
        n_cmp++; exp = exp_q.pop_front();
        if (data_readdata !== exp) begin n_err++; $display("FAIL oob_read: got %h need %h", data_readdata, exp); end
        @(posedge clk); #1;
        data_write = 1'b0;
        n_cmp++; if (bus_error !== 1'b1) begin n_err++; $display("FAIL bus_error_set: got %b need 1", bus_error); end
        data_address = 32'h0; sb_push(32'hDEADBEEF); #1;
        n_cmp++; exp = exp_q.pop_front();
        if (data_readdata !== exp) begin n_err++; $display("FAIL oob_no_write_w0: got %h need %h", data_readdata, exp); end
        data_address = 32'h10; sb_push(32'hCAFEF00D); #1;
        n_cmp++; exp = exp_q.pop_front();
        if (data_readdata !== exp) begin n_err++; $display("FAIL oob_no_write_w4: got %h need %h", data_readdata, exp); end
        repeat (3) @(posedge clk); #1;
        n_cmp++; if (bus_error !== 1'b1) begin n_err++; $display("FAIL bus_error_sticky: got %b need 1", bus_error); end
    endtask

    task automatic test_run_done();
        do_reset();
        n_cmp++; if (bus_error !== 1'b0) begin n_err++; $display("FAIL bus_error_cleared: got %b need 0", bus_error); end
        cpu_active = 1'b1;
        load_beat(1'b0, 32'h00000000, 1'b0);
        load_beat(1'b1, 32'h12345678, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        repeat (7) @(posedge clk); #1;
        n_cmp++; if ({done, run_cycles} !== {1'b0, 32'd7}) begin n_err++; $display("FAIL run7: got done=%b cyc=%0d need done=0 cyc=7", done, run_cycles); end
        cpu_active = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if ({done, cpu_reset, run_cycles} !== {2'b10, 32'd8}) begin n_err++; $display("FAIL done_entry: got done=%b rst=%b cyc=%0d need done=1 rst=0 cyc=8", done, cpu_reset, run_cycles); end
        data_address = 32'h0; data_writedata = 32'hFFFFFFFF; data_write = 1'b1;
        repeat (3) @(posedge clk); #1;
        data_write = 1'b0;
        n_cmp++; if (run_cycles !== 32'd8) begin n_err++; $display("FAIL run_cycles_frozen: got %0d need 8", run_cycles); end
        sb_push(32'h12345678); #1;
        n_cmp++; exp = exp_q.pop_front();
        if (data_readdata !== exp) begin n_err++; $display("FAIL done_write_ignored: got %h need %h", data_readdata, exp); end
        reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
        n_cmp++; if ({cpu_reset, load_ready, done} !== 3'b110) begin n_err++; $display("FAIL reset_from_done: got rst/rdy/done %b need 110", {cpu_reset, load_ready, done}); end
        n_cmp++; if (run_cycles !== 32'd0) begin n_err++; $display("FAIL reset_from_done_cycles: got %0d need 0", run_cycles); end
        sb_push(32'h12345678); #1;
        n_cmp++; exp = exp_q.pop_front();
        if (data_readdata !== exp) begin n_err++; $display("FAIL mem_kept_over_reset: got %h need %h", data_readdata, exp); end
    endtask

    task automatic test_first_cycle_inactive();
        cpu_active = 1'b0;
        load_beat(1'b1, 32'h0000AAAA, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++; if ({done, run_cycles} !== {1'b0, 32'd1}) begin n_err++; $display("FAIL first_run_cycle: got done=%b cyc=%0d need done=0 cyc=1", done, run_cycles); end
        @(posedge clk); #1;
        n_cmp++; if ({done, run_cycles} !== {1'b1, 32'd2}) begin n_err++; $display("FAIL second_run_cycle: got done=%b cyc=%0d need done=1 cyc=2", done, run_cycles); end
    endtask

    task automatic test_overflow_bounds();
        do_reset();
        for (int i = 0; i < 1024; i++)
            load_beat(1'b1, 32'hA5000000 + 32'(i), 1'b0);
        n_cmp++; if (load_overflow !== 1'b0) begin n_err++; $display("FAIL overflow_early: got %b need 0", load_overflow); end
        load_beat(1'b1, 32'hBAD0BAD0, 1'b1);
        n_cmp++; if (load_overflow !== 1'b1) begin n_err++; $display("FAIL overflow_set: got %b need 1", load_overflow); end
        data_address = 32'h0; sb_push(32'hA5000000); #1;
        n_cmp++; exp = exp_q.pop_front();
        if (data_readdata !== exp) begin n_err++; $display("FAIL overflow_w0: got %h need %h", data_readdata, exp); end
        data_address = 32'h3; sb_push(32'hA5000000); #1;
        n_cmp++; exp = exp_q.pop_front();
        if (data_readdata !== exp) begin n_err++; $display("FAIL low_bits_ignored: got %h need %h", data_readdata, exp); end
        data_address = 32'hFFC; sb_push(32'hA50003FF); #1;
        n_cmp++; exp = exp_q.pop_front();
        if (data_readdata !== exp) begin n_err++; $display("FAIL last_data_word: got %h need %h", data_readdata, exp); end
        data_address = 32'h1000; sb_push(32'h0); #1;
        n_cmp++; exp = exp_q.pop_front();
        if (data_readdata !== exp) begin n_err++; $display("FAIL data_past_end: got %h need %h", data_readdata, exp); end
        instr_address = 32'h00000000; sb_push(32'h0); #1;
        n_cmp++; exp = exp_q.pop_front();
        if (instr_readdata !== exp) begin n_err++; $display("FAIL fetch_halt_addr: got %h need %h", instr_readdata, exp); end
        instr_address = 32'hBFC01000; sb_push(32'h0); #1;
        n_cmp++; exp = exp_q.pop_front();
        if (instr_readdata !== exp) begin n_err++; $display("FAIL fetch_past_end: got %h need %h", instr_readdata, exp); end
        instr_address = 32'hBFC00007; sb_push(32'h00000008); #1;
        n_cmp++; exp = exp_q.pop_front();
        if (instr_readdata !== exp) begin n_err++; $display("FAIL fetch_low_bits: got %h need %h", instr_readdata, exp); end
        repeat (4) @(posedge clk); #1;
        n_cmp++; if (load_overflow !== 1'b1) begin n_err++; $display("FAIL overflow_sticky: got %b need 1", load_overflow); end
    endtask

    initial begin
        test_reset();
        test_load_boot();
        test_run_write();
        test_bus_error();
        test_run_done();
        test_first_cycle_inactive();
        test_overflow_bounds();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
